aes_inv_key_schedule: RTL and testbench
=======================================

Name: aes_inv_key_schedule

Overview:
- Iterative AES-128 inverse key schedule: takes the round-10 key and emits round keys 10, 9, …, 0 in order, one per accepted handshake.
- It is the reverse-direction counterpart of the forward KeyExpansion block. It feeds the decryption datapath (InvCipher rounds) without storing all 11 round keys.
- One SubWord (4 S-boxes) plus the XOR chain per step; one round key per clock when the consumer is always ready.

Parameters:
- Nb, 128, width of a round key in bits (fixed for AES-128).
- Nr, 10, number of rounds; also the index of the first key emitted.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- start  input  1  load last_key and begin a sequence; sampled only in IDLE.
- last_key  input  Nb  round-Nr key (words w[40..43], MSB = w[40] byte 0).
- key_ready  input  1  consumer accepts round_key this cycle.
- round_key  output  Nb  current round key.
- round_idx  output  4  index of round_key (Nr down to 0).
- key_valid  output  1  round_key/round_idx are valid.
- busy  output  1  sequence in progress (EMIT state).
- done  output  1  one-cycle pulse after round key 0 is accepted.

Behaviour:
- Reset (async, Rst_n=0): state=IDLE; round_key=0, round_idx=0, key_valid=0, busy=0, done=0; the Rcon register is cleared.
- States:
  - IDLE: start=1 → EMIT. On that edge: round_key<=last_key, round_idx<=Nr, key_valid<=1, busy<=1.
  - EMIT, transfer (key_valid & key_ready):
    - If round_idx>0: round_key<=prev(round_key, round_idx), round_idx<=round_idx-1, key_valid stays 1.
    - If round_idx==0: → IDLE, key_valid<=0, busy<=0, done<=1 for exactly one cycle.
  - EMIT, no transfer: hold round_key and round_idx unchanged (stall, any length).
- Latency: first key valid 1 cycle after start. With key_ready held high, 11 keys appear on 11 consecutive cycles and done follows on the next cycle.
- prev() step: current key words a0..a3 (a0 = bits 127:96) give previous words b0..b3:
  - b3 = a3^a2
  - b2 = a2^a1
  - b1 = a1^a0
  - b0 = a0 ^ SubWord(RotWord(b3)) ^ {Rcon[r],24'h0}
- RotWord/SubWord follow FIPS-197 exactly.
- Rcon[r] is the Rcon of the current round_idx r: r=10..1 → 36,1b,80,40,20,10,08,04,02,01. It comes from a 4-bit-indexed ROM or a register divided by x in GF(2^8). Either is allowed, but the values must match.
- Boundaries:
  - start while busy: ignored; last_key is not re-sampled.
  - start in the same cycle that done is asserted: accepted, since the FSM is already in IDLE. A new sequence begins the next cycle.
  - key_ready with key_valid=0: no effect.
  - round_idx never wraps below 0.
  - Rst_n asserted mid-sequence: immediate return to the reset values; no done pulse.
- round_key and round_idx are registered outputs; no combinational path from key_ready to any output.

Optional Feature:
- Macro: INV_KS_KEY0_HOLD_EN.
- Defined:
  - Adds output port cipher_key  output  Nb.
  - cipher_key is loaded with round key 0 when it is accepted and holds until the next accepted key 0 or reset (reset value 0).
  - This gives the recovered original cipher key for key-integrity checks.
- Undefined: no cipher_key port, no extra registers. Everything else is identical.

Test Plan:
- FIPS-197 vector, key_ready=1:
  - Stimulus: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start pulse.
  - Response:
    - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
    - Next cycle idx9 = ac7766f319fadc2128d12941575c006e.
    - idx1 = a0fafe1788542cb123a339392a6c7605.
    - idx0 = 2b7e151628aed2a6abf7158809cf4f3c.
    - done high exactly one cycle after idx0.
- Backpressure:
  - Stimulus: same start, key_ready toggled 1,0,0,1,…
  - Response: round_key and round_idx held stable while key_ready=0; the final key sequence is identical to the first test; 11 transfers total.
- Start while busy:
  - Stimulus: a second start at idx 7 with last_key=all-zero.
  - Response: ignored; the sequence continues to the same idx0 = 2b7e1516….
- Mid-sequence reset:
  - Stimulus: Rst_n=0 at idx 5.
  - Response: all outputs 0 asynchronously; no done pulse. After release, a new start reproduces the first test.
- Back-to-back:
  - Stimulus: start asserted in the done cycle.
  - Response: the second sequence begins with idx10 valid on the next cycle.
- INV_KS_KEY0_HOLD_EN defined:
  - Stimulus: run the first test.
  - Response: cipher_key=2b7e151628aed2a6abf7158809cf4f3c after idx0 is accepted, and it holds through later idle cycles.

Source files
------------

// File: rtl/aes_inv_key_schedule_if.sv
// Handshake bundle between the inverse key schedule and its round-key consumer.
// With INV_KS_KEY0_HOLD_EN defined the bundle also carries the recovered cipher key.
interface aes_inv_key_schedule_if #(
  parameter int NB = 128
);
  logic          start;
  logic [NB-1:0] last_key;
  logic          key_ready;
  logic [NB-1:0] round_key;
  logic [3:0]    round_idx;
  logic          key_valid;
  logic          busy;
  logic          done;
`ifdef INV_KS_KEY0_HOLD_EN
  logic [NB-1:0] cipher_key;
`endif

  modport master (
`ifdef INV_KS_KEY0_HOLD_EN
    input  cipher_key,
`endif
    output start, last_key, key_ready,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
`ifdef INV_KS_KEY0_HOLD_EN
    output cipher_key,
`endif
    input  start, last_key, key_ready,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: emits round keys Nr..0 from the round-Nr key.
// Optional INV_KS_KEY0_HOLD_EN keeps the recovered cipher key (round key 0) on cipher_key.
module aes_inv_key_schedule #(
  parameter int NB = 128,
  parameter int NR = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  aes_inv_key_schedule_if.slave ks
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0x00 sits in the top byte of the table, so the slice base is (255-b)*8 = {~b,3'b0}.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  // Division by x in GF(2^8) mod x^8+x^4+x^3+x+1: walks Rcon backwards (36,1b,80,...,01).
  function automatic logic [7:0] rcon_div_x(input logic [7:0] b);
    return b[0] ? ({1'b0, b[7:1]} ^ 8'h8d) : {1'b0, b[7:1]};
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state;
  logic [NB-1:0] round_key;
  logic [3:0]    round_idx;
  logic          key_valid;
  logic          busy;
  logic          done;
  logic [7:0]    rcon;
`ifdef INV_KS_KEY0_HOLD_EN
  logic [NB-1:0] cipher_key;
`endif

  logic [31:0]   a0, a1, a2, a3;
  logic [31:0]   b0, b1, b2, b3;
  logic [NB-1:0] prev_key;
  logic          xfer;

  assign {a0, a1, a2, a3} = round_key;
  assign b3       = a3 ^ a2;
  assign b2       = a2 ^ a1;
  assign b1       = a1 ^ a0;
  assign b0       = a0 ^ sub_word(rot_word(b3)) ^ {rcon, 24'h0};
  assign prev_key = {b0, b1, b2, b3};
  assign xfer     = key_valid & ks.key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round_key  <= '0;
      round_idx  <= '0;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rcon       <= '0;
`ifdef INV_KS_KEY0_HOLD_EN
      cipher_key <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ks.start) begin
            state     <= EMIT;
            round_key <= ks.last_key;
            round_idx <= 4'(NR);
            key_valid <= 1'b1;
            busy      <= 1'b1;
            rcon      <= 8'h36;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (round_idx != 4'd0) begin
              round_key <= prev_key;
              round_idx <= round_idx - 4'd1;
              rcon      <= rcon_div_x(rcon);
            end else begin
              state      <= IDLE;
              key_valid  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
`ifdef INV_KS_KEY0_HOLD_EN
              cipher_key <= round_key;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ks.round_key  = round_key;
  assign ks.round_idx  = round_idx;
  assign ks.key_valid  = key_valid;
  assign ks.busy       = busy;
  assign ks.done       = done;
`ifdef INV_KS_KEY0_HOLD_EN
  assign ks.cipher_key = cipher_key;
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: random and FIPS-197 keys checked against a forward
// KeyExpansion model built from GF(2^8) arithmetic.
module tb_aes_inv_key_schedule;

  localparam logic [127:0] FIPS_CK = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_inv_key_schedule_if #(.NB(128)) ks ();

  aes_inv_key_schedule #(.NB(128), .NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  sb [256];
  logic [31:0] w  [44];
`ifdef INV_KS_KEY0_HOLD_EN
  logic [127:0] last_k0 = '0;
`endif

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gf_mul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] ck);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    {w[0], w[1], w[2], w[3]} = ck;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_key"}, ks.round_key, '0);
    check_eq({tag, "_idx"}, ks.round_idx, '0);
    check_eq({tag, "_ctl"}, {ks.key_valid, ks.busy, ks.done}, '0);
`ifdef INV_KS_KEY0_HOLD_EN
    check_eq({tag, "_cipher"}, ks.cipher_key, '0);
`endif
  endtask

  task automatic drive_start(input logic [127:0] ck);
    expand(ck);
    ks.last_key  = rk(10);
    ks.start     = 1'b1;
    ks.key_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    ks.start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ks.key_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("idle_ctl", {ks.key_valid, ks.busy, ks.done}, '0);
`ifdef INV_KS_KEY0_HOLD_EN
      check_eq("cipher_hold", ks.cipher_key, last_k0);
`endif
    end
  endtask

  // mode 0: always ready, 1: pattern 1,0,0,..., 2: random ready
  task automatic run_body(input int mode, input int inject_at, input bit fips,
                          input bit chain, input logic [127:0] next_ck);
    int   e = 10;
    int   xfers = 0;
    int   cyc = 0;
    int   phase = 0;
    bit   injected = 0;
    bit   r;
    logic [127:0] k0;
    while (e >= 0 && cyc < 400) begin
      check_eq("valid_busy", {ks.key_valid, ks.busy}, 2'b11);
      check_eq($sformatf("idx%0d", e), ks.round_idx, e[3:0]);
      check_eq($sformatf("key%0d", e), ks.round_key, rk(e));
      check_eq("done_low", ks.done, 1'b0);
      if (fips) begin
        case (e)
          10: check_eq("fips10", ks.round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
          9:  check_eq("fips9",  ks.round_key, 128'hac7766f319fadc2128d12941575c006e);
          1:  check_eq("fips1",  ks.round_key, 128'ha0fafe1788542cb123a339392a6c7605);
          0:  check_eq("fips0",  ks.round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
          default: ;
        endcase
      end
      case (mode)
        0:       r = 1'b1;
        1:       begin r = (phase % 3 == 0); phase++; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      ks.start = 1'b0;
      if (e == inject_at && !injected) begin
        ks.start    = 1'b1;
        ks.last_key = '0;
        injected    = 1;
      end
      ks.key_ready = r;
      @(negedge clk);
      cyc++;
      if (r) begin
        e--;
        xfers++;
      end
    end
    ks.start = 1'b0;
    check_eq("xfers", xfers, 11);
    check_eq("done_pulse", {ks.done, ks.key_valid, ks.busy}, 3'b100);
    k0 = rk(0);
`ifdef INV_KS_KEY0_HOLD_EN
    check_eq("cipher_key", ks.cipher_key, k0);
    last_k0 = k0;
`endif
    ks.key_ready = 1'($urandom_range(0, 1));
    if (chain) begin
      expand(next_ck);
      ks.last_key = rk(10);
      ks.start    = 1'b1;
    end
    @(negedge clk);
    ks.start = 1'b0;
    check_eq("done_clear", ks.done, 1'b0);
    if (!chain) check_eq("back_idle", {ks.key_valid, ks.busy}, '0);
`ifdef INV_KS_KEY0_HOLD_EN
    check_eq("cipher_hold", ks.cipher_key, k0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    ks.start     = 1'b0;
    ks.last_key  = '0;
    ks.key_ready = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    // FIPS-197 vector, consumer always ready
    drive_start(FIPS_CK);
    run_body(0, -1, 1, 0, '0);
    idle_cycles(3);

    // backpressure
    drive_start(FIPS_CK);
    run_body(1, -1, 1, 0, '0);
    idle_cycles(1);

    // start with an all-zero key while busy at idx 7
    drive_start(FIPS_CK);
    run_body(0, 7, 1, 0, '0);
    idle_cycles(1);

    // reset while idx 5 is presented
    drive_start(FIPS_CK);
    for (int e = 10; e > 5; e--) begin
      check_eq("pre_rst_idx", ks.round_idx, e[3:0]);
      ks.key_ready = 1'b1;
      @(negedge clk);
    end
    check_eq("pre_rst_idx5", ks.round_idx, 4'd5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_eq("midrst_nodone", ks.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef INV_KS_KEY0_HOLD_EN
    last_k0 = '0;
`endif
    idle_cycles(2);
    drive_start(FIPS_CK);
    run_body(0, -1, 1, 0, '0);

    // back-to-back: second start lands in the done cycle
    drive_start(FIPS_CK);
    run_body(0, -1, 1, 1, {$urandom(), $urandom(), $urandom(), $urandom()});
    run_body(2, -1, 0, 0, '0);
    idle_cycles(1);

    // random keys, random backpressure and idle gaps
    for (int k = 0; k < 8; k++) begin
      drive_start({$urandom(), $urandom(), $urandom(), $urandom()});
      run_body(2, (k % 2 == 0) ? int'($urandom_range(0, 10)) : -1, 0, 0, '0);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
